// File: rtl/bp_pkg.sv
// Shared branch-prediction definitions.
// Holds the BTB entry layout, the 2-bit counter encodings, the default index
// width and the saturating counter update function.
package bp_pkg;

  localparam int IDX_BITS_DEF = 6;

  localparam logic [1:0] CTR_SNT = 2'd0;  // strongly not-taken
  localparam logic [1:0] CTR_WNT = 2'd1;  // weakly not-taken
  localparam logic [1:0] CTR_WT  = 2'd2;  // weakly taken
  localparam logic [1:0] CTR_ST  = 2'd3;  // strongly taken

  // The tag field is sized for the narrowest legal index (PC[31:2]), so one
  // layout serves every IDX_BITS; the unused upper tag bits are always zero.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } entry_t;

  function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// 2-bit saturating counter next-value logic.
// Ports:
//   ctr_i   - current counter value
//   taken_i - resolved branch outcome
//   ctr_o   - counter value after training (saturates at 0 and 3)
module btb_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  assign ctr_o = sat_ctr_next(ctr_i, taken_i);

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// IF side: combinational lookup of PCF producing PredF / NPC_PredF.
// EX side: resolves the carried prediction, raises MispredE with the correct
// next PC, and trains the table on ValidE & EnE.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   PCF                     - fetch PC
//   PredF, NPC_PredF        - prediction for PCF
//   ValidE, EnE             - EX holds a real instruction / EX not stalled
//   PCE, IsBranchE, TakenE,
//   BrTargetE               - resolved branch information
//   PredE, NPC_PredE        - prediction carried down to EX
//   MispredE, NPC_CorrectE  - redirect request and correct next PC
//   BrCount, MispredCount   - statistics, only with BTB_STATS_EN defined
// Optional macro: BTB_STATS_EN adds the two statistics counters.
module branch_target_buffer
  import bp_pkg::*;
#(
  parameter int         IDX_BITS = IDX_BITS_DEF,
  parameter logic [1:0] CTR_INIT = CTR_WNT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  output logic        PredF,
  output logic [31:0] NPC_PredF,
  input  logic        ValidE,
  input  logic        EnE,
  input  logic [31:0] PCE,
  input  logic        IsBranchE,
  input  logic        TakenE,
  input  logic [31:0] BrTargetE,
  input  logic        PredE,
  input  logic [31:0] NPC_PredE,
  output logic        MispredE,
`ifdef BTB_STATS_EN
  output logic [31:0] NPC_CorrectE,
  output logic [31:0] BrCount,
  output logic [31:0] MispredCount
`else
  output logic [31:0] NPC_CorrectE
`endif
);

  localparam int DEPTH = 2 ** IDX_BITS;

  logic              valid_q  [DEPTH];
  logic [1:0]        ctr_q    [DEPTH];
  logic [29:0]       tag_q    [DEPTH];
  logic [31:0]       target_q [DEPTH];

  // ---------------- lookup ----------------
  logic [IDX_BITS-1:0] idx_f;
  logic [29:0]         tag_f;
  entry_t              ent_f;
  logic                hit_f;

  assign idx_f = PCF[IDX_BITS+1:2];
  assign tag_f = 30'(PCF >> (IDX_BITS + 2));

  always_comb begin
    ent_f        = '0;
    ent_f.valid  = valid_q[idx_f];
    ent_f.tag    = tag_q[idx_f];
    ent_f.target = target_q[idx_f];
    ent_f.ctr    = ctr_q[idx_f];
  end

  assign hit_f     = ent_f.valid && (ent_f.tag == tag_f);
  assign PredF     = hit_f && ent_f.ctr[1];
  assign NPC_PredF = PredF ? ent_f.target : PCF + 32'd4;

  // ---------------- resolution ----------------
  logic [31:0] actual_e;

  assign actual_e     = (IsBranchE && TakenE) ? BrTargetE : PCE + 32'd4;
  assign MispredE     = ValidE && (NPC_PredE != actual_e);
  assign NPC_CorrectE = actual_e;

  // ---------------- training ----------------
  logic [IDX_BITS-1:0] idx_e;
  logic [29:0]         tag_e;
  entry_t              ent_e;
  logic                hit_e;
  logic                upd_e;
  logic                wr_ctr, wr_tgt, wr_alloc, wr_inval;
  logic [1:0]          ctr_trained;

  assign idx_e = PCE[IDX_BITS+1:2];
  assign tag_e = 30'(PCE >> (IDX_BITS + 2));

  always_comb begin
    ent_e        = '0;
    ent_e.valid  = valid_q[idx_e];
    ent_e.tag    = tag_q[idx_e];
    ent_e.target = target_q[idx_e];
    ent_e.ctr    = ctr_q[idx_e];
  end

  assign hit_e = ent_e.valid && (ent_e.tag == tag_e);
  assign upd_e = ValidE && EnE;

  btb_sat_counter u_sat_counter (
    .ctr_i   (ent_e.ctr),
    .taken_i (TakenE),
    .ctr_o   (ctr_trained)
  );

  always_comb begin
    wr_ctr   = 1'b0;
    wr_tgt   = 1'b0;
    wr_alloc = 1'b0;
    wr_inval = 1'b0;
    if (upd_e) begin
      if (IsBranchE) begin
        wr_ctr   = hit_e;
        wr_tgt   = hit_e && TakenE;
        wr_alloc = !hit_e && TakenE;
      end else begin
        // A non-branch matching an entry means the entry is stale.
        wr_inval = hit_e;
      end
    end
  end

  // Control fields carry the reset; a reset edge overrides any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_INIT;
      end
    end else begin
      if (wr_alloc) begin
        valid_q[idx_e] <= 1'b1;
        ctr_q[idx_e]   <= CTR_WT;
      end else if (wr_ctr) begin
        ctr_q[idx_e]   <= ctr_trained;
      end else if (wr_inval) begin
        valid_q[idx_e] <= 1'b0;
      end
    end
  end

  // Tags and targets are meaningless while valid=0, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_alloc) begin
      tag_q[idx_e]    <= tag_e;
      target_q[idx_e] <= BrTargetE;
    end else if (wr_tgt) begin
      target_q[idx_e] <= BrTargetE;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mis_cnt_q, mis_cnt_d;

  assign br_cnt_d  = br_cnt_q + 32'((ValidE && EnE && IsBranchE) ? 1 : 0);
  assign mis_cnt_d = mis_cnt_q + 32'((MispredE && EnE) ? 1 : 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign BrCount      = br_cnt_q;
  assign MispredCount = mis_cnt_q;
`endif

  // The carried prediction bit is implied by NPC_PredE; low PC bits are
  // always zero for aligned instructions.
  logic unused_ok;
  assign unused_ok = ^{PredE, PCF[1:0], PCE[1:0]};

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PCF;
  logic        PredF;
  logic [31:0] NPC_PredF;
  logic        ValidE, EnE, IsBranchE, TakenE, PredE;
  logic [31:0] PCE, BrTargetE, NPC_PredE;
  logic        MispredE;
  logic [31:0] NPC_CorrectE;
`ifdef BTB_STATS_EN
  logic [31:0] BrCount, MispredCount;
`endif

  int checks = 0;
  int failures = 0;

  branch_target_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PCF          (PCF),
    .PredF        (PredF),
    .NPC_PredF    (NPC_PredF),
    .ValidE       (ValidE),
    .EnE          (EnE),
    .PCE          (PCE),
    .IsBranchE    (IsBranchE),
    .TakenE       (TakenE),
    .BrTargetE    (BrTargetE),
    .PredE        (PredE),
    .NPC_PredE    (NPC_PredE),
    .MispredE     (MispredE),
`ifdef BTB_STATS_EN
    .NPC_CorrectE (NPC_CorrectE),
    .BrCount      (BrCount),
    .MispredCount (MispredCount)
`else
    .NPC_CorrectE (NPC_CorrectE)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive an EX-stage slot; the table trains at the next posedge if ValidE & EnE.
  task automatic ex(input logic v, input logic en, input logic [31:0] pc, input logic br,
                    input logic tk, input logic [31:0] tgt, input logic [31:0] npc_pred);
    ValidE = v; EnE = en; PCE = pc; IsBranchE = br; TakenE = tk;
    BrTargetE = tgt; NPC_PredE = npc_pred; PredE = (npc_pred != pc + 32'd4);
  endtask

  task automatic idle_ex();
    ex(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h4);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    PCF   = 32'h100;
    idle_ex();
    #3;
    chk("rst_predf", {31'b0, PredF}, 32'd0);
    chk("rst_npc", NPC_PredF, 32'h104);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_miss", {31'b0, PredF}, 32'd0);

    // First taken branch: miss allocate; lookup in same cycle sees old entry.
    ex(1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 32'h104);
    #1;
    chk("alloc_mispred", {31'b0, MispredE}, 32'd1);
    chk("alloc_correct", NPC_CorrectE, 32'h200);
    chk("same_cycle_old_pred", {31'b0, PredF}, 32'd0);
    chk("same_cycle_old_npc", NPC_PredF, 32'h104);
    step();
    idle_ex();
    #1;
    chk("trained_pred", {31'b0, PredF}, 32'd1);
    chk("trained_npc", NPC_PredF, 32'h200);

    // Stalled or bubble not-taken resolutions must not train (ctr stays 2).
    ex(1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h200, 32'h200);
    step();
    ex(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h200);
    #1;
    chk("bubble_no_mispred", {31'b0, MispredE}, 32'd0);
    step();
    idle_ex();
    #1;
    chk("hold_pred", {31'b0, PredF}, 32'd1);

    // Not taken twice: 2->1->0.
    ex(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h200);
    #1;
    chk("nt1_mispred", {31'b0, MispredE}, 32'd1);
    chk("nt1_correct", NPC_CorrectE, 32'h104);
    step();
    idle_ex();
    #1;
    chk("nt1_pred", {31'b0, PredF}, 32'd0);
    chk("nt1_npc", NPC_PredF, 32'h104);
    ex(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h104);
    #1;
    chk("nt2_mispred", {31'b0, MispredE}, 32'd0);
    step();
    // Saturate at 0, then two takens (new targets) climb to 2.
    ex(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h104);
    step();
    ex(1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 32'h240, 32'h104);
    step();
    idle_ex();
    #1;
    chk("sat0_pred", {31'b0, PredF}, 32'd0);
    ex(1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 32'h280, 32'h104);
    step();
    idle_ex();
    #1;
    chk("ctr2_pred", {31'b0, PredF}, 32'd1);
    chk("tgt_overwrite", NPC_PredF, 32'h280);
    // Saturate at 3: two more takens, then one not-taken leaves ctr=2.
    ex(1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 32'h280, 32'h280);
    step();
    step();
    ex(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h280, 32'h280);
    step();
    idle_ex();
    #1;
    chk("sat3_pred", {31'b0, PredF}, 32'd1);

    // Non-branch with matching tag invalidates; TakenE ignored for non-branch.
    ex(1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 32'h900, 32'h104);
    #1;
    chk("nonbr_mispred", {31'b0, MispredE}, 32'd0);
    chk("nonbr_correct", NPC_CorrectE, 32'h104);
    step();
    idle_ex();
    #1;
    chk("inval_pred", {31'b0, PredF}, 32'd0);

    // Alias: 0x300 shares the index of 0x100 and replaces it.
    ex(1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 32'h104);
    step();
    ex(1'b1, 1'b1, 32'h300, 1'b1, 1'b1, 32'h400, 32'h304);
    step();
    idle_ex();
    #1;
    chk("alias_old_pred", {31'b0, PredF}, 32'd0);
    chk("alias_old_npc", NPC_PredF, 32'h104);
    PCF = 32'h300;
    #1;
    chk("alias_new_pred", {31'b0, PredF}, 32'd1);
    chk("alias_new_npc", NPC_PredF, 32'h400);

    // Modulo-2^32 wrap of +4.
    PCF = 32'hFFFF_FFFC;
    ex(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("wrap_npcf", NPC_PredF, 32'h0);
    chk("wrap_correct", NPC_CorrectE, 32'h0);
    chk("wrap_mispred", {31'b0, MispredE}, 32'd0);
    step();

    // Asynchronous reset between edges clears the table at once.
    PCF = 32'h300;
    idle_ex();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pred", {31'b0, PredF}, 32'd0);
    chk("async_rst_npc", NPC_PredF, 32'h304);
    step();
    rst_n = 1'b1;
    step();
    chk("after_rst_pred", {31'b0, PredF}, 32'd0);

`ifdef BTB_STATS_EN
    chk("stats_rst_br", BrCount, 32'd0);
    chk("stats_rst_mis", MispredCount, 32'd0);
    // Five counted branches, two of them mispredicted.
    ex(1'b1, 1'b1, 32'h500, 1'b1, 1'b1, 32'h600, 32'h600); step();
    ex(1'b1, 1'b1, 32'h500, 1'b1, 1'b1, 32'h600, 32'h504); step();
    ex(1'b1, 1'b1, 32'h500, 1'b1, 1'b0, 32'h600, 32'h504); step();
    ex(1'b1, 1'b1, 32'h700, 1'b1, 1'b0, 32'h800, 32'h800); step();
    ex(1'b1, 1'b1, 32'h700, 1'b1, 1'b0, 32'h800, 32'h704); step();
    // Bubble with a bogus carried NPC, and a stalled mispredicting branch.
    ex(1'b0, 1'b1, 32'h900, 1'b1, 1'b1, 32'hA00, 32'h904); step();
    ex(1'b1, 1'b0, 32'h900, 1'b1, 1'b1, 32'hA00, 32'h904); step();
    idle_ex();
    #1;
    chk("stats_br", BrCount, 32'd5);
    chk("stats_mis", MispredCount, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("stats_clr_br", BrCount, 32'd0);
    chk("stats_clr_mis", MispredCount, 32'd0);
    step();
    rst_n = 1'b1;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
